// File: rtl/bsg_chip_io_link_gearbox.sv
// Bidirectional wide<->narrow gearbox in front of an IO link channel tunnel input.
// Optional flit counters are enabled by defining BSG_CHIP_IO_LINK_GEARBOX_STATS_EN.
module bsg_chip_io_link_gearbox #(
  parameter int unsigned wide_width_p   = 128,
  parameter int unsigned narrow_width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      wide_v_i,
  input  logic [wide_width_p-1:0]   wide_data_i,
  output logic                      wide_ready_and_o,
  output logic                      narrow_v_o,
  output logic [narrow_width_p-1:0] narrow_data_o,
  input  logic                      narrow_ready_and_i,
  input  logic                      narrow_v_i,
  input  logic [narrow_width_p-1:0] narrow_data_i,
  output logic                      narrow_ready_and_o,
  output logic                      wide_v_o,
  output logic [wide_width_p-1:0]   wide_data_o,
  input  logic                      wide_ready_and_i
`ifdef BSG_CHIP_IO_LINK_GEARBOX_STATS_EN
  ,
  output logic [31:0]               out_flit_cnt_o,
  output logic [31:0]               in_flit_cnt_o
`endif
);

  localparam int unsigned ratio_lp = wide_width_p / narrow_width_p;
  localparam int unsigned cnt_w_lp = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(ratio_lp - 1);

  if ((narrow_width_p == 0) || ((wide_width_p % narrow_width_p) != 0)) begin : g_width_check
    $error("narrow_width_p must divide wide_width_p exactly");
  end

  // ---------------- outbound: wide flit -> narrow beats ----------------
  typedef enum logic {OUT_EMPTY, OUT_SEND} out_state_e;

  out_state_e                              out_state_r, out_state_n;
  logic [ratio_lp-1:0][narrow_width_p-1:0] out_data_r;
  logic [cnt_w_lp-1:0]                     out_cnt_r;
  logic                                    out_last;
  logic                                    out_beat_xfer;
  logic                                    out_wide_xfer;

  assign out_last = (out_cnt_r == last_cnt_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) out_state_r <= OUT_EMPTY;
    else            out_state_r <= out_state_n;
  end

  always_comb begin
    out_state_n = out_state_r;
    case (out_state_r)
      OUT_EMPTY: if (wide_v_i) out_state_n = OUT_SEND;
      OUT_SEND:  if (out_beat_xfer && out_last && !wide_v_i) out_state_n = OUT_EMPTY;
      default:   out_state_n = OUT_EMPTY;
    endcase
  end

  // Ready opens on the last beat so a waiting flit loads with no bubble.
  always_comb begin
    narrow_v_o       = (out_state_r == OUT_SEND);
    out_beat_xfer    = narrow_v_o & narrow_ready_and_i;
    wide_ready_and_o = (out_state_r == OUT_EMPTY) | (out_beat_xfer & out_last);
    out_wide_xfer    = wide_v_i & wide_ready_and_o;
    narrow_data_o    = out_data_r[out_cnt_r];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_data_r <= '0;
      out_cnt_r  <= '0;
    end else if (out_wide_xfer) begin
      out_data_r <= wide_data_i;
      out_cnt_r  <= '0;
    end else if (out_beat_xfer) begin
      out_cnt_r  <= out_last ? '0 : out_cnt_r + 1'b1;
    end
  end

  // ---------------- inbound: narrow beats -> wide flit ----------------
  typedef enum logic {IN_COLLECT, IN_FULL} in_state_e;

  in_state_e                               in_state_r, in_state_n;
  logic [ratio_lp-1:0][narrow_width_p-1:0] in_data_r;
  logic [cnt_w_lp-1:0]                     in_cnt_r;
  logic                                    in_last;
  logic                                    in_beat_xfer;

  assign in_last = (in_cnt_r == last_cnt_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) in_state_r <= IN_COLLECT;
    else            in_state_r <= in_state_n;
  end

  // In FULL the counter sits at 0, so only a single-beat ratio can refill straight back to FULL.
  always_comb begin
    in_state_n = in_state_r;
    case (in_state_r)
      IN_COLLECT: if (in_beat_xfer && in_last) in_state_n = IN_FULL;
      IN_FULL:    if (wide_ready_and_i && !(in_beat_xfer && in_last)) in_state_n = IN_COLLECT;
      default:    in_state_n = IN_COLLECT;
    endcase
  end

  always_comb begin
    wide_v_o           = (in_state_r == IN_FULL);
    narrow_ready_and_o = !wide_v_o | wide_ready_and_i;
    in_beat_xfer       = narrow_v_i & narrow_ready_and_o;
    wide_data_o        = in_data_r;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_data_r <= '0;
      in_cnt_r  <= '0;
    end else if (in_beat_xfer) begin
      in_data_r[in_cnt_r] <= narrow_data_i;
      in_cnt_r            <= in_last ? '0 : in_cnt_r + 1'b1;
    end
  end

`ifdef BSG_CHIP_IO_LINK_GEARBOX_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_flit_cnt_o <= '0;
      in_flit_cnt_o  <= '0;
    end else begin
      if (out_beat_xfer && out_last)   out_flit_cnt_o <= out_flit_cnt_o + 32'd1;
      if (wide_v_o && wide_ready_and_i) in_flit_cnt_o <= in_flit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_chip_io_link_gearbox.sv
// Scoreboard bench for bsg_chip_io_link_gearbox: directed vectors, random stalls, mid-flit reset.
module tb_bsg_chip_io_link_gearbox;
  localparam int unsigned W = 128;
  localparam int unsigned N = 32;
  localparam int unsigned R = W / N;

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic         wide_v_i;
  logic [W-1:0] wide_data_i;
  logic         wide_ready_and_o;
  logic         narrow_v_o;
  logic [N-1:0] narrow_data_o;
  logic         narrow_ready_and_i;
  logic         narrow_v_i;
  logic [N-1:0] narrow_data_i;
  logic         narrow_ready_and_o;
  logic         wide_v_o;
  logic [W-1:0] wide_data_o;
  logic         wide_ready_and_i;
`ifdef BSG_CHIP_IO_LINK_GEARBOX_STATS_EN
  logic [31:0]  out_flit_cnt_o;
  logic [31:0]  in_flit_cnt_o;
`endif

  bsg_chip_io_link_gearbox #(.wide_width_p(W), .narrow_width_p(N)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n_i),
    .wide_v_i           (wide_v_i),
    .wide_data_i        (wide_data_i),
    .wide_ready_and_o   (wide_ready_and_o),
    .narrow_v_o         (narrow_v_o),
    .narrow_data_o      (narrow_data_o),
    .narrow_ready_and_i (narrow_ready_and_i),
    .narrow_v_i         (narrow_v_i),
    .narrow_data_i      (narrow_data_i),
    .narrow_ready_and_o (narrow_ready_and_o),
    .wide_v_o           (wide_v_o),
    .wide_data_o        (wide_data_o),
    .wide_ready_and_i   (wide_ready_and_i)
`ifdef BSG_CHIP_IO_LINK_GEARBOX_STATS_EN
    ,
    .out_flit_cnt_o     (out_flit_cnt_o),
    .in_flit_cnt_o      (in_flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] out_q[$];
  logic [W-1:0] in_q[$];
  int out_rdy_mode = 1;  // 0 low, 1 high, 2 random
  int in_rdy_mode  = 1;
  int unsigned out_beats_seen = 0;
  int unsigned out_flits_seen = 0;
  int unsigned in_flits_seen  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Ready drivers settle 2 time units after the edge so the main thread can retarget them at +1.
  always @(posedge clk) begin
    #2;
    case (out_rdy_mode)
      0:       narrow_ready_and_i = 1'b0;
      1:       narrow_ready_and_i = 1'b1;
      default: narrow_ready_and_i = ($urandom_range(0, 3) != 0);
    endcase
    case (in_rdy_mode)
      0:       wide_ready_and_i = 1'b0;
      1:       wide_ready_and_i = 1'b1;
      default: wide_ready_and_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: a transfer is pending whenever valid & ready are high at the falling edge.
  always @(negedge clk) begin
    if (reset_n_i) begin
      if (narrow_v_o && narrow_ready_and_i) begin
        if (out_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL out_extra_beat actual=%h required=none", narrow_data_o);
        end else begin
          check("out_beat", W'(narrow_data_o), W'(out_q.pop_front()));
        end
        out_beats_seen++;
        if (out_beats_seen % R == 0) out_flits_seen++;
      end
      if (wide_v_o && wide_ready_and_i) begin
        if (in_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL in_extra_flit actual=%h required=none", wide_data_o);
        end else begin
          check("in_flit", wide_data_o, in_q.pop_front());
        end
        in_flits_seen++;
      end
    end
  end

  task automatic push_out(input logic [W-1:0] f);
    for (int i = 0; i < R; i++) out_q.push_back(f[i*N +: N]);
  endtask

  // Entered and left at posedge+1.
  task automatic send_flit(input logic [W-1:0] f);
    int unsigned n = 0;
    bit ok = 1'b1;
    wide_v_i    = 1'b1;
    wide_data_i = f;
    forever begin
      @(negedge clk);
      if (wide_ready_and_o) break;
      n++;
      if (n > 200) begin
        checks++; failures++; ok = 1'b0;
        $display("FAIL send_flit_timeout actual=stalled required=accept");
        break;
      end
    end
    if (ok) push_out(f);
    @(posedge clk); #1;
    wide_v_i = 1'b0;
  endtask

  task automatic send_beats(input logic [W-1:0] f, input int first, input int last,
                            input bit push, input bit gaps);
    for (int b = first; b <= last; b++) begin
      int unsigned n = 0;
      bit ok = 1'b1;
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      narrow_v_i    = 1'b1;
      narrow_data_i = f[b*N +: N];
      forever begin
        @(negedge clk);
        if (narrow_ready_and_o) break;
        n++;
        if (n > 200) begin
          checks++; failures++; ok = 1'b0;
          $display("FAIL send_beat_timeout actual=stalled required=accept");
          break;
        end
      end
      if (ok && push && b == last) in_q.push_back(f);
      @(posedge clk); #1;
      narrow_v_i = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_rdy_mode = 1;
    in_rdy_mode  = 1;
    while ((out_q.size() != 0 || in_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_queue_empty", W'(out_q.size()), '0);
    check("in_queue_empty",  W'(in_q.size()),  '0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i     = 1'b0;
    wide_v_i      = 1'b0;
    wide_data_i   = '0;
    narrow_v_i    = 1'b0;
    narrow_data_i = '0;
    narrow_ready_and_i = 1'b1;
    wide_ready_and_i   = 1'b1;
    #1;
    check("rst_narrow_v",   W'(narrow_v_o), '0);
    check("rst_wide_v",     W'(wide_v_o), '0);
    check("rst_narrow_dat", W'(narrow_data_o), '0);
    check("rst_wide_dat",   wide_data_o, '0);
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    check("rst_wide_rdy",   W'(wide_ready_and_o), W'(1));
    check("rst_narrow_rdy", W'(narrow_ready_and_o), W'(1));
    @(posedge clk); #1;

    // Single outbound flit: LSB slice first, ready low during the 3 non-final beats.
    wide_v_i    = 1'b1;
    wide_data_i = 128'h0000000D_0000000C_0000000B_0000000A;
    @(negedge clk);
    check("t1_accept", W'(wide_ready_and_o), W'(1));
    out_q.push_back(32'hA); out_q.push_back(32'hB);
    out_q.push_back(32'hC); out_q.push_back(32'hD);
    @(posedge clk); #1;
    wide_v_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1_beat_v",   W'(narrow_v_o), W'(1));
      check("t1_wide_rdy", W'(wide_ready_and_o), W'(c == 3));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t1_idle", W'(narrow_v_o), '0);
    @(posedge clk); #1;

    // Back-to-back: F1 taken in F0's last-beat cycle, 8 beats with no gap.
    wide_v_i    = 1'b1;
    wide_data_i = 128'h00000004_00000003_00000002_00000001;
    @(negedge clk);
    check("t2_accept0", W'(wide_ready_and_o), W'(1));
    push_out(128'h00000004_00000003_00000002_00000001);
    @(posedge clk); #1;
    wide_data_i = 128'h00000008_00000007_00000006_00000005;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_beat_v", W'(narrow_v_o), W'(1));
      if (c == 3) begin
        check("t2_accept1", W'(wide_ready_and_o), W'(1));
        push_out(128'h00000008_00000007_00000006_00000005);
      end
      @(posedge clk); #1;
      if (c == 3) wide_v_i = 1'b0;
    end

    // Inbound with core stalled: flit held, beats refused, then drain + refill together.
    in_rdy_mode = 0;
    send_beats(128'h00000044_00000033_00000022_00000011, 0, 3, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_full_v",   W'(wide_v_o), W'(1));
      check("t3_blocked",  W'(narrow_ready_and_o), '0);
      check("t3_hold_dat", wide_data_o, 128'h00000044_00000033_00000022_00000011);
      @(posedge clk); #1;
    end
    in_rdy_mode   = 1;
    narrow_v_i    = 1'b1;
    narrow_data_i = 32'h55;
    @(negedge clk);
    check("t3_refill_rdy", W'(narrow_ready_and_o), W'(1));
    @(posedge clk); #1;
    narrow_v_i = 1'b0;
    send_beats(128'h00000088_00000077_00000066_00000055, 1, 3, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_latency", W'(wide_v_o), W'(1));
    @(posedge clk); #1;
    drain();

    // Random stalls on all four handshakes, 1000 flits each way.
    out_rdy_mode = 2;
    in_rdy_mode  = 2;
    fork
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_flit({$urandom, $urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 1000; i++) begin
        send_beats({$urandom, $urandom, $urandom, $urandom}, 0, R - 1, 1'b1, 1'b1);
      end
    join
    drain();

    // Reset with a half-collected inbound flit and an outbound flit mid-SEND.
    send_beats(128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001, 0, 1, 1'b0, 1'b0);
    send_flit(128'hBEEF0004_BEEF0003_BEEF0002_BEEF0001);
    @(posedge clk); #1;
    reset_n_i = 1'b0;
    #1;
    check("t5_narrow_v",   W'(narrow_v_o), '0);
    check("t5_wide_v",     W'(wide_v_o), '0);
    check("t5_narrow_dat", W'(narrow_data_o), '0);
    check("t5_wide_dat",   wide_data_o, '0);
    check("t5_wide_rdy",   W'(wide_ready_and_o), W'(1));
    check("t5_narrow_rdy", W'(narrow_ready_and_o), W'(1));
    out_q.delete();
    in_q.delete();
    out_beats_seen = 0;
    out_flits_seen = 0;
    in_flits_seen  = 0;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    send_beats(128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 0, 3, 1'b1, 1'b0);
    send_flit(128'hF00D0004_F00D0003_F00D0002_F00D0001);
    drain();

`ifdef BSG_CHIP_IO_LINK_GEARBOX_STATS_EN
    for (int i = 0; i < 4; i++) begin
      send_flit({4{32'(i)}});
      send_beats({4{32'(i + 16)}}, 0, 3, 1'b1, 1'b0);
    end
    drain();
    check("stats_out", W'(out_flit_cnt_o), W'(5));
    check("stats_in",  W'(in_flit_cnt_o),  W'(5));
    check("stats_out_model", W'(out_flits_seen), W'(5));
    check("stats_in_model",  W'(in_flits_seen),  W'(5));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
